// File: rtl/pipe_ctrl_if.sv
// Stall/flush bus between the pipeline stages and pipe_ctrl.
// slave: controller side, master: pipeline side.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              stallreq_if_i;
  logic              stallreq_id_i;
  logic              stallreq_ex_i;
  logic              stallreq_mem_i;
  logic              jmp_wrong_i;
  logic [ADDR_W-1:0] jmp_target_i;
  logic              if_busy_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] flush_pc_o;
  logic              if_discard_o;
  logic              drain_timeout_o;
  logic [31:0]       stall_cnt_o;
  logic [31:0]       flush_cnt_o;

  modport slave (
    input  stallreq_if_i, stallreq_id_i,
    input  stallreq_ex_i, stallreq_mem_i,
    input  jmp_wrong_i, jmp_target_i,
    input  if_busy_i,
    output stall_o, flush_o, flush_pc_o,
    output if_discard_o, drain_timeout_o,
    output stall_cnt_o, flush_cnt_o
  );

  modport master (
    output stallreq_if_i, stallreq_id_i,
    output stallreq_ex_i, stallreq_mem_i,
    output jmp_wrong_i, jmp_target_i,
    output if_busy_i,
    input  stall_o, flush_o, flush_pc_o,
    input  if_discard_o, drain_timeout_o,
    input  stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with mispredict hold and IF drain.
// CTRL_PERF_EN adds saturating stall/flush event counters.
module pipe_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DRAIN_MAX = 15
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DRAIN
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(DRAIN_MAX - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [5:0]        code;
  logic              hold;
  logic              draining;
  logic              fire;
  logic [ADDR_W-1:0] fire_pc;
  logic              timeout;

  always_comb begin
    code = 6'b000000;
    priority case (1'b1)
      bus.stallreq_mem_i: code = 6'b011111;
      bus.stallreq_ex_i:  code = 6'b001111;
      bus.stallreq_id_i:  code = 6'b000111;
      bus.stallreq_if_i:  code = 6'b000011;
      default:            code = 6'b000000;
    endcase
  end

  // A flush may only issue when id_ex is not frozen.
  assign hold     = code[3];
  assign draining = (state_q == DRAIN) && bus.if_busy_i;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    fire_pc = '0;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.jmp_wrong_i) begin
          if (hold) begin
            tgt_d   = bus.jmp_target_i;
            state_d = PEND;
          end else begin
            fire    = 1'b1;
            fire_pc = bus.jmp_target_i;
          end
        end
      end
      PEND: begin
        if (!hold) begin
          fire    = 1'b1;
          fire_pc = tgt_q;
        end
      end
      DRAIN: begin
        if (bus.jmp_wrong_i && hold) begin
          tgt_d   = bus.jmp_target_i;
          state_d = PEND;
          cnt_d   = '0;
        end else if (bus.jmp_wrong_i) begin
          fire    = 1'b1;
          fire_pc = bus.jmp_target_i;
        end else if (!bus.if_busy_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      state_d = bus.if_busy_i ? DRAIN : IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.stall_o         = '0;
    bus.flush_o         = 1'b0;
    bus.flush_pc_o      = '0;
    bus.if_discard_o    = 1'b0;
    bus.drain_timeout_o = 1'b0;
    if (!rst) begin
      bus.stall_o         = code | {4'b0000, draining, draining};
      bus.flush_o         = fire;
      bus.flush_pc_o      = fire_pc;
      bus.if_discard_o    = draining;
      bus.drain_timeout_o = timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((bus.stall_o != 6'b0) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.flush_o && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle reference model
// and literal spot checks.
module tb_pipe_ctrl;

  localparam int AW   = 32;
  localparam int DMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(AW)) bus ();

  pipe_ctrl #(
    .ADDR_W   (AW),
    .DRAIN_MAX(DMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending redirect, drain in progress, drain age.
  bit          m_pend;
  logic [31:0] m_ptgt;
  bit          m_drain;
  int          m_age;
  logic [31:0] m_scnt, m_fcnt;

  initial begin
    m_pend = 0; m_ptgt = '0; m_drain = 0; m_age = 0;
    m_scnt = '0; m_fcnt = '0;
  end

  always @(negedge clk) begin
    logic [5:0]  e_stall;
    logic        e_flush, e_disc, e_to, hold, busy;
    logic [31:0] e_pc;
    e_stall = '0; e_flush = 0; e_pc = '0; e_disc = 0; e_to = 0;
    busy = bus.if_busy_i;
    hold = bus.stallreq_mem_i | bus.stallreq_ex_i;
    if (!rst) begin
      if (bus.stallreq_mem_i)     e_stall = 6'd31;
      else if (bus.stallreq_ex_i) e_stall = 6'd15;
      else if (bus.stallreq_id_i) e_stall = 6'd7;
      else if (bus.stallreq_if_i) e_stall = 6'd3;
      if (m_drain && busy) begin
        e_stall = e_stall | 6'd3;
        e_disc  = 1;
      end
      if (m_pend && !hold) begin
        e_flush = 1; e_pc = m_ptgt;
      end else if (!m_pend && bus.jmp_wrong_i && !hold) begin
        e_flush = 1; e_pc = bus.jmp_target_i;
      end else if (!m_pend && bus.jmp_wrong_i) begin
        m_pend = 1; m_ptgt = bus.jmp_target_i;
        m_drain = 0; m_age = 0;
      end else if (m_drain && !m_pend) begin
        if (!busy) begin
          m_drain = 0; m_age = 0;
        end else if (m_age + 1 == DMAX) begin
          e_to = 1; m_drain = 0; m_age = 0;
        end else begin
          m_age++;
        end
      end
      if (e_flush) begin
        m_pend = 0; m_drain = busy; m_age = 0;
      end
    end
    chk("outputs",
        {17'b0, e_stall, e_flush, e_disc, e_to, e_pc},
        {17'b0, bus.stall_o, bus.flush_o, bus.if_discard_o,
         bus.drain_timeout_o, bus.flush_pc_o});
    if (bus.flush_o && bus.stall_o[3]) begin
      checks++; failures++;
      $display("FAIL flush_vs_ex_stall: flush=1 stall=%b", bus.stall_o);
    end
`ifdef CTRL_PERF_EN
    chk("counters", {m_scnt, m_fcnt}, {bus.stall_cnt_o, bus.flush_cnt_o});
`else
    chk("counters", 64'd0, {bus.stall_cnt_o, bus.flush_cnt_o});
`endif
    if (rst) begin
      m_pend = 0; m_ptgt = '0; m_drain = 0; m_age = 0;
      m_scnt = '0; m_fcnt = '0;
    end else begin
      if (e_stall != 0) m_scnt++;
      if (e_flush) m_fcnt++;
    end
  end

  // req = {mem, ex, id, if}
  task automatic cyc(input logic r, input logic [3:0] req,
                     input logic jmp, input logic [31:0] tgt,
                     input logic busy);
    @(posedge clk);
    #1;
    rst = r;
    {bus.stallreq_mem_i, bus.stallreq_ex_i,
     bus.stallreq_id_i, bus.stallreq_if_i} = req;
    bus.jmp_wrong_i  = jmp;
    bus.jmp_target_i = tgt;
    bus.if_busy_i    = busy;
    @(negedge clk);
  endtask

  initial begin
    bus.stallreq_if_i = 0; bus.stallreq_id_i = 0;
    bus.stallreq_ex_i = 0; bus.stallreq_mem_i = 0;
    bus.jmp_wrong_i = 0; bus.jmp_target_i = '0; bus.if_busy_i = 0;

    cyc(1, 4'b0000, 0, 0, 0);
    cyc(1, 4'b1000, 0, 0, 0);
    chk("reset_stall", bus.stall_o, 6'b0);
    chk("reset_flush", bus.flush_o, 0);

    cyc(0, 4'b0011, 0, 0, 0);
    chk("stall_id_if", bus.stall_o, 6'b000111);
    cyc(0, 4'b1011, 0, 0, 0);
    chk("stall_mem", bus.stall_o, 6'b011111);
    cyc(0, 4'b0101, 0, 0, 0);
    chk("stall_ex", bus.stall_o, 6'b001111);
    cyc(0, 4'b0001, 0, 0, 0);
    chk("stall_if", bus.stall_o, 6'b000011);

    cyc(0, 4'b0000, 1, 32'h100, 0);
    chk("flush_now", {bus.flush_o, bus.flush_pc_o}, {1'b1, 32'h100});
    cyc(0, 4'b0000, 0, 0, 0);
    chk("flush_1cyc", {bus.flush_o, bus.flush_pc_o}, 33'd0);

    cyc(0, 4'b1000, 1, 32'h200, 0);
    chk("pend_0", bus.flush_o, 0);
    cyc(0, 4'b1000, 1, 32'h300, 0);
    chk("pend_1", bus.flush_o, 0);
    cyc(0, 4'b1000, 0, 0, 0);
    chk("pend_2", bus.flush_o, 0);
    cyc(0, 4'b0000, 0, 0, 0);
    chk("pend_rel", {bus.flush_o, bus.flush_pc_o}, {1'b1, 32'h200});
    cyc(0, 4'b0000, 0, 0, 0);
    chk("pend_done", bus.flush_o, 0);

    cyc(0, 4'b0000, 1, 32'h400, 1);
    chk("drain_flush", {bus.flush_o, bus.if_discard_o}, 2'b10);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'b0000, 0, 0, 1);
      chk("drain_disc", {bus.if_discard_o, bus.stall_o}, 7'b1000011);
    end
    cyc(0, 4'b0000, 0, 0, 0);
    chk("drain_exit", {bus.if_discard_o, bus.stall_o}, 7'b0);

    cyc(0, 4'b0000, 1, 32'h500, 1);
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 4'b0000, 0, 0, 1);
      chk("timeout", {bus.drain_timeout_o, bus.if_discard_o},
          {i == 15, 1'b1});
    end
    cyc(0, 4'b0000, 0, 0, 1);
    chk("post_timeout", {bus.drain_timeout_o, bus.if_discard_o}, 2'b00);

    cyc(0, 4'b0000, 1, 32'h600, 1);
    cyc(0, 4'b0000, 0, 0, 1);
    cyc(0, 4'b0000, 0, 0, 1);
    cyc(0, 4'b0000, 1, 32'h700, 1);
    chk("reflush", {bus.flush_o, bus.if_discard_o, bus.flush_pc_o},
        {2'b11, 32'h700});
    cyc(0, 4'b0000, 0, 0, 1);
    cyc(0, 4'b0000, 0, 0, 0);

    cyc(0, 4'b1000, 1, 32'h800, 0);
    cyc(1, 4'b1000, 0, 0, 0);
    chk("rst_pend", {bus.flush_o, bus.stall_o}, 7'b0);
    cyc(0, 4'b0000, 0, 0, 0);
    chk("rst_drop", bus.flush_o, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0010, 0, 0, 0);
    cyc(0, 4'b0000, 1, 32'h900, 0);
    cyc(0, 4'b0000, 0, 0, 0);
`ifdef CTRL_PERF_EN
    chk("perf", {bus.stall_cnt_o, bus.flush_cnt_o}, {32'd5, 32'd1});
`else
    chk("perf", {bus.stall_cnt_o, bus.flush_cnt_o}, 64'd0);
`endif
    cyc(0, 4'b0000, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
